// File: rtl/wb_regfile.sv
// Write-back stage: selects the MEM/WB result, commits it into a 32-entry register file,
// serves two bypassed ID read ports and keeps a saturating count of committed writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WB_RegWriteIn,
  input  logic              WB_MemtoRegIn,
  input  logic [DATA_W-1:0] ReadDataIn,
  input  logic [DATA_W-1:0] ALURIn,
  input  logic [ADDR_W-1:0] MuxIn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic [CNT_W-1:0]  WbCount
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Register 0 is hardwired to zero, so storage starts at index 1.
  logic [DATA_W-1:0] regs [1:DEPTH-1];

  logic write_en;
  logic commit;
  logic cnt_max;

  assign WriteData = WB_MemtoRegIn ? ReadDataIn : ALURIn;

  // Bypass and commit share one qualifier: a live write that is not held in reset.
  assign write_en = rst_n && WB_RegWriteIn;
  assign commit   = write_en && (MuxIn != '0);
  assign cnt_max  = (WbCount == {CNT_W{1'b1}});

  // NOTE: the register array is cleared by reset because every entry must read zero
  // after reset; this costs a reset mux per bit and keeps it out of RAM macros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        regs[i] <= '0;
      end
      WbCount <= '0;
    end else if (commit) begin
      regs[MuxIn] <= WriteData;
      if (!cnt_max) begin
        WbCount <= WbCount + CNT_W'(1);
      end
    end
  end

  always_comb begin
    // NOTE: the output gets a default first so no path through the block infers a latch.
    ReadData1 = '0;
    if (ReadReg1 == '0) begin
      ReadData1 = '0;
    end else if (write_en && (MuxIn == ReadReg1)) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = regs[ReadReg1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (ReadReg2 == '0) begin
      ReadData2 = '0;
    end else if (write_en && (MuxIn == ReadReg2)) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = regs[ReadReg2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: table of per-cycle vectors with hand-computed results,
// plus hand sequences for reset hold and counter saturation on a narrow-counter instance.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        mtr;
  logic [31:0] rdata;
  logic [31:0] alu;
  logic [4:0]  mux;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic [31:0] rd1, rd2, wd;
  logic [15:0] cnt;
  logic [31:0] rd1_n, rd2_n, wd_n;
  logic [3:0]  cnt_n;

  int tests = 0;
  int fails = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .WB_RegWriteIn(we), .WB_MemtoRegIn(mtr),
    .ReadDataIn(rdata), .ALURIn(alu), .MuxIn(mux), .ReadReg1(r1), .ReadReg2(r2),
    .ReadData1(rd1), .ReadData2(rd2), .WriteData(wd), .WbCount(cnt)
  );

  wb_regfile #(.CNT_W(4)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .WB_RegWriteIn(we), .WB_MemtoRegIn(mtr),
    .ReadDataIn(rdata), .ALURIn(alu), .MuxIn(mux), .ReadReg1(r1), .ReadReg2(r2),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .WriteData(wd_n), .WbCount(cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic        mtr;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  mux;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_wd;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic w, input logic m, input logic [31:0] rdv,
                       input logic [31:0] a, input logic [4:0] mx,
                       input logic [4:0] p1, input logic [4:0] p2);
    rst_n = rs; we = w; mtr = m; rdata = rdv; alu = a; mux = mx; r1 = p1; r2 = p2;
  endtask

  initial begin
    // rst, we, mtr, rdata, alu, mux, r1, r2, rd1, rd2, wd, cnt (after the edge)
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd0,
                 32'h0000_1234, 32'h0, 32'h0000_1234, 16'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5,
                 32'h0000_1234, 32'h0000_1234, 32'h0, 16'd1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd31, 5'd31, 5'd31,
                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h0, 32'h1, 5'd31, 5'd31, 5'd31,
                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 16'd2};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd5,
                 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 16'd2};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'hAA, 5'd7, 5'd7, 5'd31,
                 32'hAA, 32'hDEAD_BEEF, 32'hAA, 16'd3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h55, 5'd7, 5'd7, 5'd7,
                 32'hAA, 32'hAA, 32'h55, 16'd3};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h10, 5'd3, 5'd3, 5'd7,
                 32'h10, 32'hAA, 32'h10, 16'd4};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h77, 32'h0, 5'd5, 5'd5, 5'd3,
                 32'h77, 32'h10, 32'h77, 16'd5};
    // Reset asserted with a write pending: no bypass, stored value still visible pre-edge.
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 5'd3, 5'd3, 5'd5,
                 32'h10, 32'h77, 32'h20, 16'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 5'd3, 5'd3, 5'd5,
                 32'h0, 32'h0, 32'h20, 16'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h5, 5'd9, 5'd31, 5'd7,
                 32'h0, 32'h0, 32'h5, 16'd0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_ABCD, 5'd9, 5'd9, 5'd9,
                 32'h0000_ABCD, 32'h0000_ABCD, 32'h0000_ABCD, 16'd1};

    // Hold reset across two rising edges, with a write pending that must be dropped.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h99, 5'd5, 5'd5, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_cnt", {16'h0, cnt}, 32'h0);
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].we, vecs[i].mtr, vecs[i].rdata, vecs[i].alu,
            vecs[i].mux, vecs[i].r1, vecs[i].r2);
      #1;
      check($sformatf("v%0d_rd1", i), rd1, vecs[i].exp_rd1);
      check($sformatf("v%0d_rd2", i), rd2, vecs[i].exp_rd2);
      check($sformatf("v%0d_wd", i), wd, vecs[i].exp_wd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", i), {16'h0, cnt}, {16'h0, vecs[i].exp_cnt});
    end

    // Stored value after the table: reg 9 no longer relies on the bypass.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd3);
    #1;
    check("stored_r9", rd1, 32'h0000_ABCD);
    check("cleared_r3", rd2, 32'h0);

    // Counter saturation: reset both instances, then commit 20 writes.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    check("sat_reset_narrow", {28'h0, cnt_n}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'(i + 100), 5'((i % 31) + 1), 5'd1, 5'd2);
      @(posedge clk);
      #1;
      check($sformatf("sat_narrow_%0d", i), {28'h0, cnt_n},
            (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    check("sat_wide_20", {16'h0, cnt}, 32'd20);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd20, 5'd2);
    #1;
    check("sat_stored_r20", rd1, 32'd119);
    check("sat_stored_r2", rd2, 32'd101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
